// File: rtl/accel_frame_avg_if.sv
// Byte stream in from the SPI receive path and averaged XYZ frame out to the display decoders.
// master drives the bytes and observes results; slave is the averaging block.
interface accel_frame_avg_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [1:0] byte_index;
  logic [7:0] x_avg;
  logic [7:0] y_avg;
  logic [7:0] z_avg;
  logic       avg_valid;

  modport master (
    output byte_valid, byte_data, byte_index,
    input  x_avg, y_avg, z_avg, avg_valid
  );

  modport slave (
    input  byte_valid, byte_data, byte_index,
    output x_avg, y_avg, z_avg, avg_valid
  );
endinterface

// File: rtl/accel_frame_avg.sv
// Assembles X/Y/Z byte triples into frames and averages 2^LOG2_N frames per axis; AVG_ROUND_EN adds round-half-up.
// Last Z byte to avg_valid pulse: 2 cycles; no backpressure, every byte_valid cycle is consumed.
module accel_frame_avg #(
  parameter int LOG2_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  accel_frame_avg_if.slave bus,
  input  logic             err_clr,
  output logic [LOG2_N:0]  frame_cnt,
  output logic             seq_err
);
  localparam int AW = 8 + LOG2_N;
  localparam int SW = AW + 1;
  localparam logic [LOG2_N:0] LAST_CNT = (LOG2_N + 1)'((1 << LOG2_N) - 1);
`ifdef AVG_ROUND_EN
  localparam logic [SW-1:0] RND = SW'((1 << LOG2_N) >> 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {WAIT_X, WAIT_Y, WAIT_Z, ACCUM} state_t;

  state_t        state;
  logic [7:0]    x_s, y_s, z_s;
  logic [7:0]    pend_x, pend_y, pend_z;
  logic [AW-1:0] acc_x, acc_y, acc_z;
  logic          fin;
  logic          err_set;
  logic          last_frame;
  logic [SW-1:0] sum_x, sum_y, sum_z;
  logic [SW-1:0] shr_x, shr_y, shr_z;
  logic          unused_hi;

  // Sum is one bit wider than the accumulator so the rounding offset can never wrap.
  always_comb begin
    sum_x = SW'($signed(acc_x)) + SW'($signed(x_s)) + RND;
    sum_y = SW'($signed(acc_y)) + SW'($signed(y_s)) + RND;
    sum_z = SW'($signed(acc_z)) + SW'($signed(z_s)) + RND;
    shr_x = $signed(sum_x) >>> LOG2_N;
    shr_y = $signed(sum_y) >>> LOG2_N;
    shr_z = $signed(sum_z) >>> LOG2_N;
  end

  assign unused_hi  = ^{shr_x[SW-1:8], shr_y[SW-1:8], shr_z[SW-1:8]};
  assign last_frame = (frame_cnt == LAST_CNT);

  // ACCUM accepts a byte under the same rules as WAIT_X.
  always_comb begin
    err_set = 1'b0;
    if (bus.byte_valid) begin
      case (state)
        WAIT_Y:  err_set = (bus.byte_index != 2'd1);
        WAIT_Z:  err_set = (bus.byte_index != 2'd2);
        default: err_set = (bus.byte_index != 2'd0);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_X;
      x_s           <= '0;
      y_s           <= '0;
      z_s           <= '0;
      pend_x        <= '0;
      pend_y        <= '0;
      pend_z        <= '0;
      acc_x         <= '0;
      acc_y         <= '0;
      acc_z         <= '0;
      fin           <= 1'b0;
      frame_cnt     <= '0;
      seq_err       <= 1'b0;
      bus.x_avg     <= '0;
      bus.y_avg     <= '0;
      bus.z_avg     <= '0;
      bus.avg_valid <= 1'b0;
    end else begin
      seq_err       <= err_set | (seq_err & ~err_clr);
      bus.avg_valid <= fin;
      fin           <= 1'b0;
      if (fin) begin
        bus.x_avg <= pend_x;
        bus.y_avg <= pend_y;
        bus.z_avg <= pend_z;
      end

      if (state == ACCUM) begin
        if (last_frame) begin
          pend_x    <= shr_x[7:0];
          pend_y    <= shr_y[7:0];
          pend_z    <= shr_z[7:0];
          fin       <= 1'b1;
          acc_x     <= '0;
          acc_y     <= '0;
          acc_z     <= '0;
          frame_cnt <= '0;
        end else begin
          acc_x     <= acc_x + AW'($signed(x_s));
          acc_y     <= acc_y + AW'($signed(y_s));
          acc_z     <= acc_z + AW'($signed(z_s));
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      case (state)
        WAIT_Y: begin
          if (bus.byte_valid) begin
            case (bus.byte_index)
              2'd0:    x_s <= bus.byte_data;
              2'd1: begin
                y_s   <= bus.byte_data;
                state <= WAIT_Z;
              end
              default: state <= WAIT_X;
            endcase
          end
        end
        WAIT_Z: begin
          if (bus.byte_valid) begin
            case (bus.byte_index)
              2'd0: begin
                x_s   <= bus.byte_data;
                state <= WAIT_Y;
              end
              2'd2: begin
                z_s   <= bus.byte_data;
                state <= ACCUM;
              end
              default: state <= WAIT_X;
            endcase
          end
        end
        default: begin
          state <= WAIT_X;
          if (bus.byte_valid && bus.byte_index == 2'd0) begin
            x_s   <= bus.byte_data;
            state <= WAIT_Y;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accel_frame_avg.sv
// Drives one byte stream into LOG2_N=2 and LOG2_N=0 instances; a frame-level model feeds per-instance scoreboards.
// Follows AVG_ROUND_EN when the bundle is built with it.
module tb_accel_frame_avg;
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic       bv;
  logic [7:0] bd;
  logic [1:0] bi;
  logic [2:0] fc2;
  logic [0:0] fc0;
  logic       se2, se0;

  accel_frame_avg_if bus2();
  accel_frame_avg_if bus0();

  assign bus2.byte_valid = bv;
  assign bus2.byte_data  = bd;
  assign bus2.byte_index = bi;
  assign bus0.byte_valid = bv;
  assign bus0.byte_data  = bd;
  assign bus0.byte_index = bi;

  accel_frame_avg #(.LOG2_N(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .err_clr(err_clr), .frame_cnt(fc2), .seq_err(se2)
  );
  accel_frame_avg #(.LOG2_N(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .err_clr(err_clr), .frame_cnt(fc0), .seq_err(se0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // Reference model state: index expected next, captured samples, per-instance window sums.
  int   need;
  int   cx, cy, cz;
  int   lg  [2] = '{2, 0};
  int   sx  [2];
  int   sy  [2];
  int   sz  [2];
  int   wc  [2];
  int   fce [2];
  logic merr;
  exp_t q2[$];
  exp_t q0[$];
  logic [23:0] last_o [2];

  function automatic int avg_ref(input int s, input int l);
    int n;
    int t;
    int q;
    n = 1 << l;
    t = s;
`ifdef AVG_ROUND_EN
    if (l > 0) t = t + n / 2;
`endif
    q = t / n;
    if ((t % n) != 0 && t < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    need = 0;
    cx = 0; cy = 0; cz = 0;
    merr = 1'b0;
    for (int m = 0; m < 2; m++) begin
      sx[m] = 0; sy[m] = 0; sz[m] = 0; wc[m] = 0; fce[m] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic [1:0] idx, input logic [7:0] d, input logic clr);
    logic errs;
    logic done;
    exp_t e;
    errs = 1'b0;
    done = 1'b0;
    for (int m = 0; m < 2; m++) fce[m] = wc[m];
    if (v) begin
      if (idx == 2'd0) begin
        errs = (need != 0);
        cx   = $signed(d);
        need = 1;
      end else if (need == 1 && idx == 2'd1) begin
        cy   = $signed(d);
        need = 2;
      end else if (need == 2 && idx == 2'd2) begin
        cz   = $signed(d);
        need = 0;
        done = 1'b1;
      end else begin
        errs = 1'b1;
        need = 0;
      end
    end
    merr = errs | (merr & ~clr);
    if (done) begin
      for (int m = 0; m < 2; m++) begin
        sx[m] += cx; sy[m] += cy; sz[m] += cz;
        wc[m]++;
        if (wc[m] == (1 << lg[m])) begin
          e.x   = 8'(avg_ref(sx[m], lg[m]));
          e.y   = 8'(avg_ref(sy[m], lg[m]));
          e.z   = 8'(avg_ref(sz[m], lg[m]));
          e.due = ncyc + 3;
          if (m == 0) q2.push_back(e);
          else        q0.push_back(e);
          sx[m] = 0; sy[m] = 0; sz[m] = 0; wc[m] = 0;
        end
      end
    end
  endtask

  task automatic mon_one(input int m, input logic v, input logic [23:0] act);
    exp_t e;
    bit   have;
    have = (m == 0) ? (q2.size() > 0) : (q0.size() > 0);
    if (have) e = (m == 0) ? q2[0] : q0[0];
    if (have && e.due < ncyc) begin
      total++; bad++;
      $display("FAIL avg_missing dut%0d actual=none required=%h at=%0d", m, {e.x, e.y, e.z}, e.due);
      if (m == 0) void'(q2.pop_front());
      else        void'(q0.pop_front());
      return;
    end
    total++;
    if (v) begin
      if (!have) begin
        bad++;
        $display("FAIL avg_unexpected dut%0d actual=%h required=none", m, act);
      end else begin
        if (act !== {e.x, e.y, e.z} || e.due != ncyc) begin
          bad++;
          $display("FAIL avg_value dut%0d actual=%h@%0d required=%h@%0d", m, act, ncyc, {e.x, e.y, e.z}, e.due);
        end
        last_o[m] = {e.x, e.y, e.z};
        if (m == 0) void'(q2.pop_front());
        else        void'(q0.pop_front());
      end
    end else if (act !== last_o[m]) begin
      bad++;
      $display("FAIL avg_hold dut%0d actual=%h required=%h", m, act, last_o[m]);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      last_o[0] = '0;
      last_o[1] = '0;
    end else begin
      mon_one(0, bus2.avg_valid, {bus2.x_avg, bus2.y_avg, bus2.z_avg});
      mon_one(1, bus0.avg_valid, {bus0.x_avg, bus0.y_avg, bus0.z_avg});
    end
  end

  // Entered at a falling edge, returns at the next falling edge.
  task automatic send(input logic v, input logic [1:0] idx, input logic [7:0] d, input logic clr);
    bv = v; bi = idx; bd = d; err_clr = clr;
    @(posedge clk);
    model_step(v, idx, d, clr);
    #1;
    chk("seq_err_n4", 32'(se2), 32'(merr));
    chk("seq_err_n1", 32'(se0), 32'(merr));
    chk("frame_cnt_n4", 32'(fc2), 32'(fce[0]));
    chk("frame_cnt_n1", 32'(fc0), 32'(fce[1]));
    @(negedge clk);
    bv = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    send(1'b1, 2'd0, x, 1'b0);
    send(1'b1, 2'd1, y, 1'b0);
    send(1'b1, 2'd2, z, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_n4"}, {bus2.x_avg, bus2.y_avg, bus2.z_avg, 1'b0, bus2.avg_valid, fc2, se2}, 32'h0);
    chk({nm, "_n1"}, {bus0.x_avg, bus0.y_avg, bus0.z_avg, 2'b0, bus0.avg_valid, fc0, se0}, 32'h0);
  endtask

  initial begin
    int         nxt;
    int         r;
    logic [1:0] ri;
    rst = 1'b1; bv = 1'b0; bi = 2'd0; bd = 8'h00; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Four clean frames: X ramps 10..13, Y zero, Z full-scale positive.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(10 + i), 8'h00, 8'h7F);
      idle(1);
    end
    idle(3);

    // Small negative X values exercise floor versus rounding.
    send_frame(8'hFF, 8'h01, 8'h80);
    send_frame(8'hFE, 8'h02, 8'h80);
    send_frame(8'hFF, 8'h03, 8'h81);
    send_frame(8'hFE, 8'h04, 8'h81);
    idle(3);

    // Skipped Y, recovery, clear, then clear coinciding with an illegal index.
    send(1'b1, 2'd0, 8'h11, 1'b0);
    send(1'b1, 2'd2, 8'h22, 1'b0);
    send_frame(8'h33, 8'h44, 8'h55);
    send(1'b0, 2'd0, 8'h00, 1'b1);
    send(1'b1, 2'd3, 8'h66, 1'b1);
    send(1'b0, 2'd0, 8'h00, 1'b1);

    // Repeated X: the second one wins.
    send(1'b1, 2'd0, 8'd5, 1'b0);
    send_frame(8'd7, 8'hF0, 8'h10);
    idle(3);

    // Two frames plus a stray X, then reset mid-frame.
    send_frame(8'h40, 8'h41, 8'h42);
    send_frame(8'h50, 8'h51, 8'h52);
    send(1'b1, 2'd0, 8'h60, 1'b0);
    idle(3);
    chk("queue_before_reset", 32'(q2.size() + q0.size()), 32'd0);
    rst = 1'b1;
    model_reset();
    #2;
    check_quiet("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_frame(8'(8'hF8 + 3 * i), 8'(2 * i), 8'(8'h90 - i));
    idle(3);

    // Back-to-back frames: the next X lands in the accumulate cycle.
    send_frame(8'h80, 8'h01, 8'hC0);
    send_frame(8'h7F, 8'h80, 8'h00);
    send_frame(8'h01, 8'hFF, 8'h3C);
    idle(4);

    // Mostly well-ordered random traffic with occasional disorder and clears.
    nxt = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        send(1'b0, 2'd0, 8'h00, ($urandom_range(0, 29) == 0));
      end else begin
        ri = (r < 92) ? 2'(nxt) : 2'($urandom_range(0, 3));
        send(1'b1, ri, 8'($urandom), ($urandom_range(0, 29) == 0));
        if (ri == 2'(nxt)) nxt = (nxt + 1) % 3;
        else if (ri == 2'd0) nxt = 1;
        else nxt = 0;
      end
    end
    idle(5);
    chk("queue_drained_n4", 32'(q2.size()), 32'd0);
    chk("queue_drained_n1", 32'(q0.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
